// File: rtl/branch_pkg.sv
// Shared branch-encoding types and limits, used by the branch offset encoder
// and the branch address generator.
package branch_pkg;

    localparam int unsigned BR_ADDR_W = 32;
    localparam int unsigned BR_IMM_W  = 16;
    localparam int unsigned BR_STAT_W = 16;

    localparam logic [31:0] BR_MAX_DISP = 32'h0001FFFC;
    localparam logic [31:0] BR_MIN_DISP = 32'hFFFE0000;

    typedef struct packed {
        logic align;
        logic range;
    } br_flags_t;

endpackage

// File: rtl/branch_enc_check.sv
// Combinational displacement-to-immediate conversion with alignment and
// range checking.
module branch_enc_check
    import branch_pkg::*;
#(
    parameter int unsigned ADDR_W = BR_ADDR_W,
    parameter int unsigned IMM_W  = BR_IMM_W
) (
    input  logic [ADDR_W-1:0] disp_i,
    output logic [IMM_W-1:0]  imm_o,
    output br_flags_t         flags_o
);

    logic [ADDR_W-IMM_W-2:0] upper;

    // The bits above the immediate must all replicate its sign bit.
    assign upper = disp_i[ADDR_W-1:IMM_W+1];

    always_comb begin
        imm_o         = disp_i[IMM_W+1:2];
        flags_o       = '0;
        flags_o.align = |disp_i[1:0];
        flags_o.range = !((&upper) || !(|upper));
    end

endmodule

// File: rtl/branch_offset_encoder.sv
// Two-stage valid/ready pipeline encoding branch displacements into I-type
// immediates. Define BRANCH_ENC_STATS_EN to add saturating beat/error counters.
module branch_offset_encoder
    import branch_pkg::*;
#(
    parameter int unsigned ADDR_W = BR_ADDR_W,
    parameter int unsigned IMM_W  = BR_IMM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] disp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  imm,
    output logic              err_align,
    output logic              err_range
`ifdef BRANCH_ENC_STATS_EN
   ,output logic [BR_STAT_W-1:0] stat_total,
    output logic [BR_STAT_W-1:0] stat_err
`endif
);

    logic             s1_valid_q, s1_valid_d;
    logic [IMM_W-1:0] s1_imm_q,   s1_imm_d;
    br_flags_t        s1_flags_q, s1_flags_d;

    logic             s2_valid_q, s2_valid_d;
    logic [IMM_W-1:0] s2_imm_q,   s2_imm_d;
    br_flags_t        s2_flags_q, s2_flags_d;

    logic             s1_load;
    logic             s2_load;
    logic             in_accept;
    logic [IMM_W-1:0] chk_imm;
    br_flags_t        chk_flags;

    branch_enc_check #(
        .ADDR_W(ADDR_W),
        .IMM_W (IMM_W)
    ) u_check (
        .disp_i (disp),
        .imm_o  (chk_imm),
        .flags_o(chk_flags)
    );

    assign s2_load   = !s2_valid_q || out_ready;
    assign s1_load   = !s1_valid_q || s2_load;
    assign in_ready  = !reset && s1_load;
    assign in_accept = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_flags_d = s1_flags_q;
        s2_valid_d = s2_valid_q;
        s2_imm_d   = s2_imm_q;
        s2_flags_d = s2_flags_q;

        if (s1_load) begin
            s1_valid_d = in_accept;
        end
        if (in_accept) begin
            s1_imm_d   = chk_imm;
            s1_flags_d = chk_flags;
        end

        // Payload only moves with a real beat; a drained S2 keeps its last data.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_imm_d   = s1_imm_q;
                s2_flags_d = s1_flags_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_flags_q <= '0;
            s2_valid_q <= 1'b0;
            s2_imm_q   <= '0;
            s2_flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_flags_q <= s1_flags_d;
            s2_valid_q <= s2_valid_d;
            s2_imm_q   <= s2_imm_d;
            s2_flags_q <= s2_flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign imm       = s2_imm_q;
    assign err_align = s2_flags_q.align;
    assign err_range = s2_flags_q.range;

`ifdef BRANCH_ENC_STATS_EN
    logic [BR_STAT_W-1:0] stat_total_q;
    logic [BR_STAT_W-1:0] stat_err_q;
    logic                 out_take;

    assign out_take = s2_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_total_q <= '0;
            stat_err_q   <= '0;
        end else if (out_take) begin
            if (stat_total_q != '1) begin
                stat_total_q <= stat_total_q + 1'b1;
            end
            if ((s2_flags_q.align || s2_flags_q.range) && (stat_err_q != '1)) begin
                stat_err_q <= stat_err_q + 1'b1;
            end
        end
    end

    assign stat_total = stat_total_q;
    assign stat_err   = stat_err_q;
`endif

endmodule

// File: tb/tb_branch_offset_encoder.sv
// Directed self-checking bench for branch_offset_encoder: encoding boundaries,
// latency, backpressure, mid-flight reset and (optionally) statistics counters.
module tb_branch_offset_encoder;
    import branch_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] disp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] imm;
    logic        err_align;
    logic        err_range;
`ifdef BRANCH_ENC_STATS_EN
    logic [15:0] stat_total;
    logic [15:0] stat_err;
`endif

    int unsigned n_total;
    int unsigned n_bad;

    branch_offset_encoder #(
        .ADDR_W(32),
        .IMM_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .disp      (disp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .err_align (err_align),
        .err_range (err_range)
`ifdef BRANCH_ENC_STATS_EN
       ,.stat_total(stat_total),
        .stat_err  (stat_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stream vectors: disp, expected imm, align flag, range flag.
    logic [31:0] sv_disp  [6];
    logic [15:0] sv_imm   [6];
    logic        sv_align [6];
    logic        sv_range [6];

    initial begin
        sv_disp[0] = BR_MAX_DISP;  sv_imm[0] = 16'h7FFF; sv_align[0] = 1'b0; sv_range[0] = 1'b0;
        sv_disp[1] = BR_MIN_DISP;  sv_imm[1] = 16'h8000; sv_align[1] = 1'b0; sv_range[1] = 1'b0;
        sv_disp[2] = 32'hFFFFFFFC; sv_imm[2] = 16'hFFFF; sv_align[2] = 1'b0; sv_range[2] = 1'b0;
        sv_disp[3] = 32'h00020000; sv_imm[3] = 16'h8000; sv_align[3] = 1'b0; sv_range[3] = 1'b1;
        sv_disp[4] = 32'h00000006; sv_imm[4] = 16'h0001; sv_align[4] = 1'b1; sv_range[4] = 1'b0;
        sv_disp[5] = 32'h80000002; sv_imm[5] = 16'h0000; sv_align[5] = 1'b1; sv_range[5] = 1'b1;

        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        disp      = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst.in_ready",  {31'd0, in_ready},  32'd0);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.imm",       {16'd0, imm},       32'd0);
        check("rst.err_align", {31'd0, err_align}, 32'd0);
        check("rst.err_range", {31'd0, err_range}, 32'd0);
        reset = 1'b0;
        #1;
        check("rel.in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back stream with out_ready high: 2-cycle latency, 1 beat/cycle.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check($sformatf("str%0d.valid", c - 2), {31'd0, out_valid}, 32'd1);
                check($sformatf("str%0d.imm",   c - 2), {16'd0, imm},       {16'd0, sv_imm[c-2]});
                check($sformatf("str%0d.align", c - 2), {31'd0, err_align}, {31'd0, sv_align[c-2]});
                check($sformatf("str%0d.range", c - 2), {31'd0, err_range}, {31'd0, sv_range[c-2]});
            end else begin
                check($sformatf("lat%0d.valid", c), {31'd0, out_valid}, 32'd0);
            end
            if (c < 6) begin
                check($sformatf("str%0d.in_ready", c), {31'd0, in_ready}, 32'd1);
                in_valid = 1'b1;
                disp     = sv_disp[c];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("str.drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: three beats offered, two buffered, then released in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        disp      = 32'd4;
        check("bp.rdy0", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("bp.rdy1", {31'd0, in_ready}, 32'd1);
        disp = 32'd8;
        @(negedge clk);
        check("bp.full_rdy", {31'd0, in_ready},  32'd0);
        check("bp.valid",    {31'd0, out_valid}, 32'd1);
        check("bp.imm1",     {16'd0, imm},       32'd1);
        disp = 32'd12;
        @(negedge clk);
        check("bp.hold_rdy", {31'd0, in_ready}, 32'd0);
        check("bp.hold_imm", {16'd0, imm},      32'd1);
        @(negedge clk);
        check("bp.hold2_imm", {16'd0, imm}, 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp.simul_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.valid2", {31'd0, out_valid}, 32'd1);
        check("bp.imm2",   {16'd0, imm},       32'd2);
        @(negedge clk);
        check("bp.valid3", {31'd0, out_valid}, 32'd1);
        check("bp.imm3",   {16'd0, imm},       32'd3);
        @(negedge clk);
        check("bp.empty", {31'd0, out_valid}, 32'd0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        disp      = 32'h41;
        @(negedge clk);
        disp = 32'h80;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid.valid", {31'd0, out_valid}, 32'd1);
        check("mid.imm",   {16'd0, imm},       32'h10);
        check("mid.align", {31'd0, err_align}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid.rst_rdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("mid.rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid.rst_imm",   {16'd0, imm},       32'd0);
        check("mid.rst_align", {31'd0, err_align}, 32'd0);
        check("mid.rst_range", {31'd0, err_range}, 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid.rel_rdy", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mid.ghost%0d", k), {31'd0, out_valid}, 32'd0);
        end

        // Fresh beat after reset still flows.
        in_valid = 1'b1;
        disp     = 32'hFFFFFFF8;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("post.valid", {31'd0, out_valid}, 32'd1);
        check("post.imm",   {16'd0, imm},       32'hFFFE);
        check("post.range", {31'd0, err_range}, 32'd0);
        @(negedge clk);

`ifdef BRANCH_ENC_STATS_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("st.rst_total", {16'd0, stat_total}, 32'd0);
        check("st.rst_err",   {16'd0, stat_err},   32'd0);
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1;
            case (b)
                0:       disp = 32'h4;
                1:       disp = 32'h6;
                2:       disp = 32'h100;
                3:       disp = 32'h00040000;
                default: disp = 32'h10;
            endcase
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("st.total", {16'd0, stat_total}, 32'd5);
        check("st.err",   {16'd0, stat_err},   32'd2);
        force dut.stat_total_q = 16'hFFFF;
        force dut.stat_err_q   = 16'hFFFF;
        @(negedge clk);
        release dut.stat_total_q;
        release dut.stat_err_q;
        in_valid = 1'b1;
        disp     = 32'h7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("st.sat_total", {16'd0, stat_total}, 32'h0000FFFF);
        check("st.sat_err",   {16'd0, stat_err},   32'h0000FFFF);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
